// File: rtl/instr_decode_stage.sv
// Decode stage: holds one fetched instruction, drives register-file read addresses,
// tracks in-flight destinations in a scoreboard and issues into a registered ID/EX slot.
module instr_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  output logic [4:0]  AA,
  output logic [4:0]  BA,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [6:0]  ex_opcode,
  output logic [4:0]  ex_DA,
  output logic        ex_RW,
  output logic [31:0] ex_imm,
  input  logic        wb_valid,
  input  logic [4:0]  wb_DA,
  output logic [15:0] stall_count
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned IMM_W    = 10;
  localparam int unsigned CNT_W    = 16;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] da;
    logic              rw;
    logic [DATA_W-1:0] imm;
  } ex_payload_t;

  typedef enum logic {ID_EMPTY, ID_HELD} id_state_e;
  typedef enum logic {EX_EMPTY, EX_FULL} ex_state_e;

  id_state_e           id_state_q, id_state_d;
  ex_state_e           ex_state_q, ex_state_d;
  logic [DATA_W-1:0]   id_instr_q, id_instr_d;
  ex_payload_t         ex_pay_q, ex_pay_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    stall_count_q, stall_count_d;

  logic [OPC_W-1:0]    dec_opcode;
  logic [REG_AW-1:0]   dec_da, dec_aa, dec_ba;
  logic                dec_rw, dec_uses_b;
  logic                id_valid, hazard, ex_free, issue, accept;
  logic [NUM_REGS-1:0] set_mask, clr_mask;

  // Field decode of the held instruction
  always_comb begin
    dec_opcode = id_instr_q[31:25];
    dec_da     = id_instr_q[24:20];
    dec_aa     = id_instr_q[19:15];
    dec_ba     = id_instr_q[14:10];
    dec_rw     = dec_opcode[6];
    dec_uses_b = dec_opcode[5];
  end

  // Next-state, scoreboard and handshake logic
  always_comb begin
    id_state_d    = id_state_q;
    ex_state_d    = ex_state_q;
    id_instr_d    = id_instr_q;
    ex_pay_d      = ex_pay_q;
    pending_d     = pending_q;
    stall_count_d = stall_count_q;
    set_mask      = '0;
    clr_mask      = '0;

    id_valid = (id_state_q == ID_HELD);
    hazard   = pending_q[dec_aa] || (dec_uses_b && pending_q[dec_ba]) ||
               (dec_rw && pending_q[dec_da]);
    ex_free  = (ex_state_q == EX_EMPTY) || ex_ready;
    issue    = id_valid && !hazard && ex_free;
    if_ready = rst && (!id_valid || issue);
    accept   = if_valid && if_ready;

    if (accept) begin
      id_state_d = ID_HELD;
      id_instr_d = if_instr;
    end else if (issue) begin
      id_state_d = ID_EMPTY;
    end

    if (issue) begin
      ex_state_d      = EX_FULL;
      ex_pay_d.opcode = dec_opcode;
      ex_pay_d.da     = dec_da;
      ex_pay_d.rw     = dec_rw;
      ex_pay_d.imm    = {{(DATA_W-IMM_W){id_instr_q[IMM_W-1]}}, id_instr_q[IMM_W-1:0]};
    end else if (ex_ready) begin
      ex_state_d = EX_EMPTY;
    end

    // Set is applied after clear so a same-index collision leaves the bit set
    if (wb_valid) clr_mask[wb_DA] = 1'b1;
    if (issue && dec_rw) set_mask[dec_da] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | set_mask;

    if (id_valid && hazard && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_state_q    <= ID_EMPTY;
      ex_state_q    <= EX_EMPTY;
      id_instr_q    <= '0;
      ex_pay_q      <= '0;
      pending_q     <= '0;
      stall_count_q <= '0;
    end else begin
      id_state_q    <= id_state_d;
      ex_state_q    <= ex_state_d;
      id_instr_q    <= id_instr_d;
      ex_pay_q      <= ex_pay_d;
      pending_q     <= pending_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Read addresses come straight from the holding register, forced low in reset
  always_comb begin
    AA = rst ? dec_aa : '0;
    BA = rst ? dec_ba : '0;
  end

  always_comb begin
    ex_valid    = (ex_state_q == EX_FULL);
    ex_opcode   = ex_pay_q.opcode;
    ex_DA       = ex_pay_q.da;
    ex_RW       = ex_pay_q.rw;
    ex_imm      = ex_pay_q.imm;
    stall_count = stall_count_q;
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Randomized and directed bench for instr_decode_stage against a transaction-level model.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_instr = '0;
  logic [4:0]  AA, BA;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [6:0]  ex_opcode;
  logic [4:0]  ex_DA;
  logic        ex_RW;
  logic [31:0] ex_imm;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_DA = '0;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .AA(AA), .BA(BA), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_DA(ex_DA), .ex_RW(ex_RW), .ex_imm(ex_imm), .wb_valid(wb_valid), .wb_DA(wb_DA),
    .stall_count(stall_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: queue of waiting instructions, one execute slot, per-register busy flags
  logic [31:0] m_held[$];
  logic [31:0] m_last = '0;
  bit          m_ex_full = 0;
  logic [31:0] m_ex_instr = '0;
  bit          m_busy[32];
  int          m_stalls = 0;

  function automatic logic [31:0] mk(input int op, input int da, input int aa, input int ba,
                                     input int imm);
    logic [6:0] o = 7'(op);
    logic [4:0] d = 5'(da);
    logic [4:0] a = 5'(aa);
    logic [4:0] b = 5'(ba);
    logic [9:0] i = 10'(imm);
    return {o, d, a, b, i};
  endfunction

  function automatic bit blocked(input logic [31:0] ins);
    int a = int'(ins[19:15]);
    int b = int'(ins[14:10]);
    int d = int'(ins[24:20]);
    bit writes = ins[31];
    bit reads_b = ins[30];
    return m_busy[a] || (reads_b && m_busy[b]) || (writes && m_busy[d]);
  endfunction

  function automatic logic [31:0] imm_value(input logic [31:0] ins);
    int v = int'(ins[9:0]);
    if (v >= 512) v = v - 1024;
    return 32'(v);
  endfunction

  task automatic model_reset();
    m_held.delete();
    m_last = '0;
    m_ex_full = 0;
    m_ex_instr = '0;
    m_stalls = 0;
    foreach (m_busy[k]) m_busy[k] = 0;
  endtask

  // One clock: drive on negedge, check settled outputs, advance model across posedge
  task automatic step(input bit r, input bit v, input logic [31:0] ins, input bit er,
                      input bit wv, input logic [4:0] wd);
    bit can_issue, exp_rdy;
    logic [31:0] h;
    @(negedge clk);
    rst = r; if_valid = v; if_instr = ins; ex_ready = er; wb_valid = wv; wb_DA = wd;
    #1;
    can_issue = (m_held.size() != 0) && !blocked(m_held[0]) && (!m_ex_full || er);
    exp_rdy = r && ((m_held.size() == 0) || can_issue);
    check_eq("if_ready", 32'(if_ready), 32'(exp_rdy));
    check_eq("AA", 32'(AA), r ? 32'(m_last[19:15]) : 32'd0);
    check_eq("BA", 32'(BA), r ? 32'(m_last[14:10]) : 32'd0);
    check_eq("ex_valid", 32'(ex_valid), 32'(m_ex_full));
    check_eq("ex_opcode", 32'(ex_opcode), 32'(m_ex_instr[31:25]));
    check_eq("ex_DA", 32'(ex_DA), 32'(m_ex_instr[24:20]));
    check_eq("ex_RW", 32'(ex_RW), 32'(m_ex_instr[31]));
    check_eq("ex_imm", ex_imm, imm_value(m_ex_instr));
    check_eq("stall_count", 32'(stall_count), 32'(m_stalls));
    if (!r) begin
      model_reset();
    end else begin
      if ((m_held.size() != 0) && blocked(m_held[0]) && (m_stalls < 65535)) m_stalls++;
      if (wv) m_busy[int'(wd)] = 0;
      if (can_issue) begin
        h = m_held.pop_front();
        m_ex_full = 1;
        m_ex_instr = h;
        if (h[31]) m_busy[int'(h[24:20])] = 1;
      end else if (er) begin
        m_ex_full = 0;
      end
      if (v && exp_rdy) begin
        m_held.push_back(ins);
        m_last = ins;
      end
    end
    @(posedge clk);
  endtask

  logic [31:0] rnd_ins;

  initial begin
    model_reset();
    // Reset held with fetch offering
    step(0, 1, mk(7'h40, 1, 2, 3, 0), 1, 0, 0);
    step(0, 1, mk(7'h40, 1, 2, 3, 0), 1, 0, 0);
    step(1, 0, '0, 1, 0, 0);

    // Independent stream, DA = 1..4
    for (int i = 1; i <= 4; i++) step(1, 1, mk(7'h40, i, 10, 10, i), 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 0, 0);

    // RAW on r5 released by writeback
    step(0, 0, '0, 1, 0, 0);
    step(1, 1, mk(7'h40, 5, 0, 0, 0), 1, 0, 0);
    step(1, 1, mk(7'h00, 6, 5, 0, 0), 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 1, 0, 0);
    step(1, 0, '0, 1, 1, 5);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 0, 0);

    // Port-B use gating with r7 busy
    step(1, 1, mk(7'h40, 7, 0, 0, 0), 1, 0, 0);
    step(1, 1, mk(7'h00, 8, 0, 7, 0), 1, 0, 0);
    step(1, 1, mk(7'h20, 9, 0, 7, 0), 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 0, 0);
    step(1, 0, '0, 1, 1, 7);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 0, 0);

    // Execute backpressure
    step(0, 0, '0, 0, 0, 0);
    step(1, 1, mk(7'h01, 11, 1, 1, 5), 0, 0, 0);
    step(1, 1, mk(7'h02, 12, 1, 1, 6), 0, 0, 0);
    step(1, 1, mk(7'h03, 13, 1, 1, 7), 0, 0, 0);
    step(1, 1, mk(7'h03, 13, 1, 1, 7), 0, 0, 0);
    step(1, 0, '0, 1, 0, 0);
    step(1, 0, '0, 1, 0, 0);
    step(1, 0, '0, 1, 0, 0);

    // Set/clear collision on r3 and sign-extended immediate
    step(0, 0, '0, 1, 0, 0);
    step(1, 1, mk(7'h40, 3, 0, 0, 0), 1, 0, 0);
    step(1, 1, mk(7'h00, 0, 3, 0, 10'h3FF), 1, 1, 3);
    step(1, 0, '0, 1, 0, 0);
    step(1, 0, '0, 1, 0, 0);
    step(1, 0, '0, 1, 0, 0);
    #1;
    check_eq("collision_stalls", 32'(stall_count), 32'd3);
    step(1, 0, '0, 1, 1, 3);
    step(1, 0, '0, 1, 0, 0);
    #1;
    check_eq("imm_sext", ex_imm, 32'hFFFF_FFFF);
    check_eq("imm_issue_da", 32'(ex_DA), 32'd0);

    // Randomized traffic
    step(0, 0, '0, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rnd_ins = mk(int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   ($urandom_range(0, 7) == 0) ? 10'h3FF : int'($urandom_range(0, 1023)));
      step($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1, rnd_ins,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
    end

    // Stall counter saturation
    step(0, 0, '0, 1, 0, 0);
    step(1, 1, mk(7'h40, 9, 0, 0, 0), 1, 0, 0);
    step(1, 1, mk(7'h00, 1, 9, 0, 0), 1, 0, 0);
    for (int i = 0; i < 65540; i++) step(1, 0, '0, 1, 0, 0);
    #1;
    check_eq("stall_sat", 32'(stall_count), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
